// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/dispatch stage and later pipeline stages:
// ROM chip-enable nibble, opcode map, FSM state encoding, error codes, instruction layout.
package isa_pkg;

  localparam logic [3:0] InstrMemEn = 4'h1;

  localparam logic [7:0] OP_MMULT     = 8'h00;
  localparam logic [7:0] OP_MADD      = 8'h01;
  localparam logic [7:0] OP_MSUB      = 8'h02;
  localparam logic [7:0] OP_MTRANSP   = 8'h03;
  localparam logic [7:0] OP_MSCALE    = 8'h04;
  localparam logic [7:0] OP_MSCALEIMM = 8'h05;
  localparam logic [7:0] OP_INTADD    = 8'h10;
  localparam logic [7:0] OP_INTSUB    = 8'h11;
  localparam logic [7:0] OP_INTMUL    = 8'h12;
  localparam logic [7:0] OP_INTDIV    = 8'h13;
  localparam logic [7:0] OP_STOP      = 8'hFF;

  localparam logic UNIT_MATRIX = 1'b0;
  localparam logic UNIT_INT    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_DISP,
    ST_WAIT,
    ST_HALT,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_OVERRUN = 2'b10
  } err_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier: legal dispatchable opcode, STOP, and target unit.
module instr_decode
  import isa_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       legal,
  output logic       is_stop,
  output logic       unit
);

  // Map each opcode onto its execution unit; STOP is not dispatchable.
  always_comb begin
    legal   = 1'b0;
    is_stop = 1'b0;
    unit    = UNIT_MATRIX;
    case (opcode)
      OP_MMULT, OP_MADD, OP_MSUB, OP_MTRANSP, OP_MSCALE, OP_MSCALEIMM: begin
        legal = 1'b1;
      end
      OP_INTADD, OP_INTSUB, OP_INTMUL, OP_INTDIV: begin
        legal = 1'b1;
        unit  = UNIT_INT;
      end
      OP_STOP: is_stop = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_dispatch.sv
// Fetch/decode/dispatch stage: reads one ROM word at a time, classifies it and
// hands it to the matrix or integer unit, then waits for completion before
// fetching the next word.
//
//  state | meaning
//  IDLE  | waiting for Start after reset
//  REQ   | ROM read strobe low, address driven
//  CAPT  | ROM data held; IR loads, next state chosen from the word on InstrData
//  DISP  | DispValid high until the unit accepts
//  WAIT  | instruction in flight, waiting for ExecDone
//  HALT  | STOP executed, Start restarts from PC 0
//  ERR   | illegal opcode or PC overrun, left only by Reset
module instr_fetch_dispatch
  import isa_pkg::*;
#(
  parameter int MEM_DEPTH = 10,
  parameter int PC_WIDTH  = 12
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  output logic [15:0]         InstrAddr,
  output logic                nInstrRead,
  input  logic [31:0]         InstrData,
  output logic                DispValid,
  input  logic                DispReady,
  output logic                DispUnit,
  output logic [7:0]          DispOpcode,
  output logic [7:0]          DispDest,
  output logic [7:0]          DispSrc1,
  output logic [7:0]          DispSrc2,
  input  logic                ExecDone,
  output logic [PC_WIDTH-1:0] Pc,
  output logic                Halted,
  output logic [1:0]          ErrCode
);

  state_t              state, state_nxt;
  instr_t              ir;
  logic                unit_q;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         addr_q;
  err_t                err;
  logic                cap_legal, cap_stop, cap_unit;
  logic [PC_WIDTH:0]   pc_inc;
  logic                overrun;

  // Decode straight off the ROM bus so the CAPT decision costs no extra cycle.
  instr_decode u_decode (
    .opcode  (InstrData[31:24]),
    .legal   (cap_legal),
    .is_stop (cap_stop),
    .unit    (cap_unit)
  );

  // One extra bit so the overrun compare sees Pc+1 before it could wrap.
  assign pc_inc  = {1'b0, pc} + 1'b1;
  assign overrun = (pc_inc >= (PC_WIDTH+1)'(MEM_DEPTH));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_CAPT;
      ST_CAPT: begin
        if (cap_stop)       state_nxt = ST_HALT;
        else if (cap_legal) state_nxt = ST_DISP;
        else                state_nxt = ST_ERR;
      end
      ST_DISP: if (DispReady) state_nxt = ST_WAIT;
      ST_WAIT: if (ExecDone) state_nxt = overrun ? ST_ERR : ST_REQ;
      ST_HALT: if (Start) state_nxt = ST_REQ;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: PC, ROM address, instruction register and sticky error code.
  // The address register is loaded on the way into REQ so it is already valid there.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc     <= '0;
      addr_q <= '0;
      ir     <= '0;
      unit_q <= UNIT_MATRIX;
      err    <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            pc     <= '0;
            addr_q <= {InstrMemEn, {PC_WIDTH{1'b0}}};
          end
        end
        ST_CAPT: begin
          ir     <= InstrData;
          unit_q <= cap_unit;
          if (!cap_stop && !cap_legal) err <= ERR_ILLEGAL;
        end
        ST_WAIT: begin
          if (ExecDone) begin
            if (overrun) begin
              err <= ERR_OVERRUN;
            end else begin
              pc     <= pc_inc[PC_WIDTH-1:0];
              addr_q <= {InstrMemEn, pc_inc[PC_WIDTH-1:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs derived from the current state and the captured word.
  always_comb begin
    nInstrRead = (state != ST_REQ);
    DispValid  = (state == ST_DISP);
    Halted     = (state == ST_HALT);
    InstrAddr  = addr_q;
    DispUnit   = unit_q;
    DispOpcode = ir.opcode;
    DispDest   = ir.dest;
    DispSrc1   = ir.src1;
    DispSrc2   = ir.src2;
    Pc         = pc;
    ErrCode    = err;
  end

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Self-checking bench for instr_fetch_dispatch: ROM model, execution-unit agent,
// and scoreboards of expected fetch addresses and expected dispatches.
module tb_instr_fetch_dispatch;

  typedef struct packed {
    logic       unit;
    logic [7:0] op;
    logic [7:0] dest;
    logic [7:0] s1;
    logic [7:0] s2;
  } disp_t;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] InstrAddr;
  logic        nInstrRead;
  logic [31:0] InstrData;
  logic        DispValid;
  logic        DispReady;
  logic        DispUnit;
  logic [7:0]  DispOpcode, DispDest, DispSrc1, DispSrc2;
  logic        ExecDone;
  logic [11:0] Pc;
  logic        Halted;
  logic [1:0]  ErrCode;

  logic [31:0] rom [4];
  logic [15:0] addr_q [$];
  disp_t       disp_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  int hs_cyc = 0;
  int req_cyc = 0;
  int valid_cycles = 0;
  int stall = 0;
  int done_cnt = 0;
  bit exec_en = 1'b1;
  bit stray_req = 1'b0;
  bit prev_hs = 1'b0;

  instr_fetch_dispatch #(.MEM_DEPTH(2), .PC_WIDTH(12)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .InstrAddr  (InstrAddr),
    .nInstrRead (nInstrRead),
    .InstrData  (InstrData),
    .DispValid  (DispValid),
    .DispReady  (DispReady),
    .DispUnit   (DispUnit),
    .DispOpcode (DispOpcode),
    .DispDest   (DispDest),
    .DispSrc1   (DispSrc1),
    .DispSrc2   (DispSrc2),
    .ExecDone   (ExecDone),
    .Pc         (Pc),
    .Halted     (Halted),
    .ErrCode    (ErrCode)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_disp(input logic [31:0] w);
    disp_t d;
    d.op   = w[31:24];
    d.dest = w[23:16];
    d.s1   = w[15:8];
    d.s2   = w[7:0];
    d.unit = (w[31:24] >= 8'h10) && (w[31:24] <= 8'h13);
    disp_q.push_back(d);
  endtask

  // ROM: loads Dataout on the negedge inside the read-strobe cycle, then holds.
  initial begin
    InstrData = 32'h0;
    forever begin
      @(negedge Clk);
      if (nInstrRead == 1'b0) begin
        if (InstrAddr[15:12] == 4'h1 && InstrAddr[11:0] < 12'd4)
          InstrData = rom[InstrAddr[1:0]];
        else
          InstrData = 32'hEEEE_EEEE;
      end
    end
  end

  // Fetch monitor: every read strobe must match the next expected address.
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset && nInstrRead == 1'b0) begin
        req_cyc = cyc;
        if (addr_q.size() == 0) chk_val("fetch_extra", 40'd1, 40'd0);
        else chk_val("fetch_addr", 40'(InstrAddr), 40'(addr_q.pop_front()));
      end
    end
  end

  // Execution-unit agent: stalls DispReady, checks dispatch fields each valid
  // cycle, pops on handshake and pulses ExecDone two cycles later.
  initial begin
    DispReady = 1'b0;
    ExecDone  = 1'b0;
    forever begin
      @(negedge Clk);
      ExecDone = 1'b0;
      if (stray_req) begin
        ExecDone  = 1'b1;
        stray_req = 1'b0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) ExecDone = 1'b1;
      end
      if (prev_hs) chk_val("valid_drop", 40'(DispValid), 40'd0);
      prev_hs   = 1'b0;
      DispReady = 1'b0;
      if (DispValid && !Reset) begin
        valid_cycles++;
        if (disp_q.size() == 0) begin
          chk_val("disp_unexpected", 40'd1, 40'd0);
          DispReady = 1'b1;
        end else begin
          chk_val("disp_fields", 40'({DispUnit, DispOpcode, DispDest, DispSrc1, DispSrc2}),
                  40'(disp_q[0]));
          if (stall > 0) begin
            stall--;
          end else begin
            DispReady = 1'b1;
            void'(disp_q.pop_front());
            hs_count++;
            hs_cyc  = cyc;
            prev_hs = 1'b1;
            if (exec_en) done_cnt = 2;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      if (Halted || ErrCode != 2'b00) done = 1'b1;
    end
    if (!done) chk_val("timeout_end", 40'd0, 40'd1);
  endtask

  task automatic check_reset(input string t);
    chk_val({t, "_addr"},   40'(InstrAddr),  40'h0);
    chk_val({t, "_nrd"},    40'(nInstrRead), 40'd1);
    chk_val({t, "_valid"},  40'(DispValid),  40'd0);
    chk_val({t, "_fields"}, 40'({DispUnit, DispOpcode, DispDest, DispSrc1, DispSrc2}), 40'h0);
    chk_val({t, "_pc"},     40'(Pc),         40'h0);
    chk_val({t, "_halted"}, 40'(Halted),     40'd0);
    chk_val({t, "_err"},    40'(ErrCode),    40'd0);
  endtask

  task automatic run_prog1(input string t);
    int hs0 = hs_count;
    addr_q.push_back(16'h1000);
    addr_q.push_back(16'h1001);
    exp_disp(32'h01020001);
    pulse_start();
    chk_val({t, "_c1_addr"},   40'(InstrAddr),  40'h1000);
    chk_val({t, "_c1_nrd"},    40'(nInstrRead), 40'd0);
    chk_val({t, "_c1_halted"}, 40'(Halted),     40'd0);
    @(negedge Clk);
    chk_val({t, "_c2_nrd"},    40'(nInstrRead), 40'd1);
    chk_val({t, "_c2_valid"},  40'(DispValid),  40'd0);
    @(negedge Clk);
    chk_val({t, "_c3_valid"},  40'(DispValid),  40'd1);
    chk_val({t, "_c3_fields"}, 40'({DispUnit, DispOpcode, DispDest, DispSrc1, DispSrc2}),
            40'({1'b0, 32'h01020001}));
    wait_end(40);
    chk_val({t, "_halted"},  40'(Halted),  40'd1);
    chk_val({t, "_pc"},      40'(Pc),      40'd1);
    chk_val({t, "_err"},     40'(ErrCode), 40'd0);
    chk_val({t, "_hs"},      40'(hs_count - hs0), 40'd1);
    chk_val({t, "_req_lat"}, 40'(req_cyc - hs_cyc), 40'd3);
  endtask

  initial begin
    int hs0;
    int v0;
    bit seen;
    Reset = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 32'h0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check_reset("por");

    // 1) matrix op then STOP; 6) restart from HALT repeats the sequence
    rom[0] = 32'h01020001;
    rom[1] = 32'hFF000000;
    run_prog1("t1");
    run_prog1("t6");

    // 2) integer op with DispReady stalled for 4 cycles
    do_reset();
    rom[0] = 32'h12050304;
    rom[1] = 32'hFF000000;
    addr_q.push_back(16'h1000);
    addr_q.push_back(16'h1001);
    exp_disp(32'h12050304);
    stall = 4;
    hs0 = hs_count;
    v0  = valid_cycles;
    pulse_start();
    wait_end(40);
    chk_val("t2_valid_cycles", 40'(valid_cycles - v0), 40'd5);
    chk_val("t2_hs",           40'(hs_count - hs0),    40'd1);
    chk_val("t2_halted",       40'(Halted),            40'd1);
    chk_val("t2_unit",         40'(DispUnit),          40'd0);

    // 3) illegal opcode: sticky error, Start ignored, Reset clears
    do_reset();
    rom[0] = 32'h07000000;
    addr_q.push_back(16'h1000);
    v0 = valid_cycles;
    pulse_start();
    wait_end(20);
    chk_val("t3_err",   40'(ErrCode), 40'd1);
    chk_val("t3_valid", 40'(valid_cycles - v0), 40'd0);
    pulse_start();
    repeat (5) @(negedge Clk);
    chk_val("t3_err_sticky", 40'(ErrCode),    40'd1);
    chk_val("t3_nrd",        40'(nInstrRead), 40'd1);
    chk_val("t3_halted",     40'(Halted),     40'd0);
    do_reset();
    chk_val("t3_err_cleared", 40'(ErrCode), 40'd0);

    // 4) PC overrun at MEM_DEPTH=2 without STOP
    rom[0] = 32'h10010203;
    rom[1] = 32'h11010203;
    addr_q.push_back(16'h1000);
    addr_q.push_back(16'h1001);
    exp_disp(32'h10010203);
    exp_disp(32'h11010203);
    pulse_start();
    wait_end(60);
    chk_val("t4_err", 40'(ErrCode), 40'd2);
    chk_val("t4_pc",  40'(Pc),      40'd1);
    repeat (6) @(negedge Clk);
    chk_val("t4_pc_hold", 40'(Pc),      40'd1);
    chk_val("t4_err_hold", 40'(ErrCode), 40'd2);

    // 5a) reset while in DISP
    do_reset();
    rom[0] = 32'h01020001;
    addr_q.push_back(16'h1000);
    exp_disp(32'h01020001);
    stall = 1000;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (DispValid) seen = 1'b1;
    end
    chk_val("t5a_reached_disp", 40'(seen), 40'd1);
    Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    check_reset("t5a");
    disp_q.delete();
    stall = 0;
    stray_req = 1'b1;
    repeat (4) @(negedge Clk);
    chk_val("t5a_stray_nrd", 40'(nInstrRead), 40'd1);
    chk_val("t5a_stray_pc",  40'(Pc),         40'd0);

    // 5b) reset while in WAIT, then a stray ExecDone
    exec_en = 1'b0;
    addr_q.push_back(16'h1000);
    exp_disp(32'h01020001);
    hs0 = hs_count;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (hs_count != hs0) seen = 1'b1;
    end
    chk_val("t5b_handshake", 40'(seen), 40'd1);
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    check_reset("t5b");
    stray_req = 1'b1;
    repeat (4) @(negedge Clk);
    chk_val("t5b_stray_nrd",   40'(nInstrRead), 40'd1);
    chk_val("t5b_stray_pc",    40'(Pc),         40'd0);
    chk_val("t5b_stray_valid", 40'(DispValid),  40'd0);
    exec_en = 1'b1;

    chk_val("addr_q_empty", 40'(addr_q.size()), 40'd0);
    chk_val("disp_q_empty", 40'(disp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
